// File: rtl/pcpu_pkg.sv
// Shared types and constants for the fetch side of the pipelined CPU.
package pcpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } if_state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc_p4;
      logic        valid;
   } ifid_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface if_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/if_id_reg.sv
// Pipeline record register with load, bubble and hold; used for IF/ID and the hold buffer.
module if_id_reg
   import pcpu_pkg::*;
#(
   parameter logic [31:0] NOP_INST = pcpu_pkg::NOP_INST
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load_i,
   input  logic  bubble_i,
   input  ifid_t d_i,
   output ifid_t q_o
);

   localparam ifid_t BUBBLE = '{inst: NOP_INST, pc_p4: 32'h0000_0000, valid: 1'b0};

   ifid_t q_q;

   // Load wins over bubble; otherwise the record holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= BUBBLE;
      end else if (load_i) begin
         q_q <= d_i;
      end else if (bubble_i) begin
         q_q <= BUBBLE;
      end else begin
         q_q <= q_q;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, IF/ID register and a one-word hold buffer for stalls.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
module if_stage
   import pcpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INST = pcpu_pkg::NOP_INST
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall,
   input  logic         BRANCH,
   input  logic [31:0]  target,
   if_stage_if.master   imem,
   output logic [31:0]  inst,
   output logic [31:0]  pc_p4,
   output logic         id_valid,
   output logic [31:0]  pc,
   output logic [31:0]  perf_fetch,
   output logic [31:0]  perf_wait,
   output logic [31:0]  perf_squash
);

   if_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_p4_s;
   logic        ifid_load_s, ifid_bubble_s, hold_load_s, hold_bubble_s;
   ifid_t       ifid_d_s, fetched_s, ifid_q_s, hold_q_s;

   assign pc_p4_s   = pc_q + 32'd4;
   assign fetched_s = '{inst: imem.imem_rdata, pc_p4: pc_p4_s, valid: 1'b1};

   // Next-state, PC and pipeline-register control; stall always masks BRANCH.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ifid_d_s      = fetched_s;
      ifid_load_s   = 1'b0;
      ifid_bubble_s = 1'b0;
      hold_load_s   = 1'b0;
      hold_bubble_s = 1'b0;
      case (state_q)
         IDLE: begin
            state_d       = FETCH;
            ifid_bubble_s = 1'b1;
         end
         FETCH: begin
            if (!stall && BRANCH) begin
               pc_d          = target;
               ifid_bubble_s = 1'b1;
            end else if (imem.imem_ready && !stall) begin
               pc_d        = pc_p4_s;
               ifid_load_s = 1'b1;
            end else if (imem.imem_ready) begin
               pc_d        = pc_p4_s;
               hold_load_s = 1'b1;
               state_d     = HOLD;
            end else if (!stall) begin
               ifid_bubble_s = 1'b1;
            end else begin
               ifid_bubble_s = 1'b0;
            end
         end
         HOLD: begin
            if (stall) begin
               state_d = HOLD;
            end else if (BRANCH) begin
               pc_d          = target;
               ifid_bubble_s = 1'b1;
               hold_bubble_s = 1'b1;
               state_d       = FETCH;
            end else begin
               ifid_d_s      = hold_q_s;
               ifid_load_s   = 1'b1;
               hold_bubble_s = 1'b1;
               state_d       = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state and fetch PC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   if_id_reg #(.NOP_INST(NOP_INST)) u_ifid (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (ifid_load_s),
      .bubble_i (ifid_bubble_s),
      .d_i      (ifid_d_s),
      .q_o      (ifid_q_s)
   );

   if_id_reg #(.NOP_INST(NOP_INST)) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (hold_load_s),
      .bubble_i (hold_bubble_s),
      .d_i      (fetched_s),
      .q_o      (hold_q_s)
   );

   // Reset gates the request in the same cycle so an aborted fetch is dropped at once.
   assign imem.imem_req  = rst_n & (state_q == FETCH);
   assign imem.imem_addr = pc_q;
   assign inst           = ifid_q_s.inst;
   assign pc_p4          = ifid_q_s.pc_p4;
   assign id_valid       = ifid_q_s.valid;
   assign pc             = pc_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_wait_q, perf_squash_q;
   logic        wait_s, redirect_s;

   assign wait_s     = (state_q == FETCH) & ~imem.imem_ready;
   assign redirect_s = (state_q != IDLE) & ~stall & BRANCH;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetch_q  <= 32'd0;
         perf_wait_q   <= 32'd0;
         perf_squash_q <= 32'd0;
      end else begin
         perf_fetch_q  <= ifid_load_s ? sat_inc(perf_fetch_q)  : perf_fetch_q;
         perf_wait_q   <= wait_s      ? sat_inc(perf_wait_q)   : perf_wait_q;
         perf_squash_q <= redirect_s  ? sat_inc(perf_squash_q) : perf_squash_q;
      end
   end

   assign perf_fetch  = perf_fetch_q;
   assign perf_wait   = perf_wait_q;
   assign perf_squash = perf_squash_q;
`else
   assign perf_fetch  = 32'd0;
   assign perf_wait   = 32'd0;
   assign perf_squash = 32'd0;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage with PC register, IF/ID pipeline register and a one-entry hold buffer. It sits directly upstream of the ID stage. It drives `inst`/`pc_p4` into ID and consumes ID's `target`, `BRANCH` and `stall`. It handshakes with instruction memory that may take several cycles per fetch, and it squashes the wrong-path instruction on a taken branch or jump.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, bubble encoding (sll $0,$0,0) placed in IF/ID.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  ID load-use stall: freeze PC and IF/ID.
- BRANCH  in  1  ID redirect request (branch taken, J, JAL, JR).
- target  in  32  redirect address from ID.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals `pc`.
- imem_ready  in  1  `imem_rdata` valid for `imem_addr` this cycle.
- imem_rdata  in  32  fetched word.
- inst  out  32  IF/ID instruction to ID.
- pc_p4  out  32  IF/ID PC+4 to ID.
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- pc  out  32  current fetch PC (debug).
- perf_fetch, perf_wait, perf_squash  out  32 each  counters (see Configuration).

## Operation
- FSM states: IDLE, FETCH, HOLD. Reset enters IDLE.
- Input precedence: `stall` overrides `BRANCH`. `BRANCH` is acted on only when `stall`=0, because ID operands are stale while stalled.
- IDLE:
  - `imem_req`=0.
  - Next cycle goes to FETCH. Counts as an IF/ID bubble cycle.
- FETCH: `imem_req`=1, `imem_addr`=pc, held stable until `imem_ready` or a redirect.
  - BRANCH & !stall: pc<=target, IF/ID<=bubble, `imem_rdata` discarded, stay FETCH. This aborts the outstanding request; memory samples the new address next cycle.
  - imem_ready & !stall: IF/ID<={imem_rdata, pc+4}, id_valid<=1, pc<=pc+4.
  - imem_ready & stall: hold buffer<={imem_rdata, pc+4}, pc<=pc+4, IF/ID unchanged, go HOLD.
  - !imem_ready & !stall: IF/ID<=bubble.
  - !imem_ready & stall: IF/ID unchanged.
- HOLD: `imem_req`=0.
  - stall: IF/ID and hold buffer unchanged.
  - !stall & BRANCH: hold buffer dropped, pc<=target, IF/ID<=bubble, go FETCH.
  - !stall & !BRANCH: IF/ID<=hold buffer, id_valid<=1, go FETCH.
- Bubble means inst=NOP_INST, pc_p4=0, id_valid=0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0, and pc_p4 wraps identically. pc[1:0] is taken from target unchanged; alignment is ID's responsibility.

## Timing
- Reset values:
  - pc=RESET_PC, state=IDLE.
  - inst=NOP_INST, pc_p4=0, id_valid=0.
  - imem_req=0, hold buffer cleared, perf counters=0.
- Reset mid-fetch drops the request immediately in the reset cycle: imem_req=0 that cycle and the following one (IDLE).
- First request is issued 2 cycles after rst_n rises (IDLE, then FETCH).
- Zero-wait memory (imem_ready=1 combinationally): one instruction per cycle; inst valid 1 cycle after its address is presented.
- N-wait memory: N bubble cycles into ID per fetch.
- Taken redirect costs exactly 1 squashed slot (no delay slot). Fetch at `target` starts the cycle after BRANCH is sampled.
- A redirect and imem_ready in the same cycle resolve to redirect; the word is discarded.

## Configuration
- IF_PERF_CNT_EN defined: three saturating 32-bit counters.
  - perf_fetch: increments on each IF/ID load with id_valid=1.
  - perf_wait: increments on each FETCH cycle with imem_ready=0.
  - perf_squash: increments on each accepted redirect.
- IF_PERF_CNT_EN undefined: counters absent, perf_* tied to 0, no other behavioural change.

## Structure
- Shared package pcpu_pkg holds:
  - NOP_INST constant.
  - if_state_t enum {IDLE, FETCH, HOLD}.
  - RESET_PC default.
  - ifid_t struct {inst, pc_p4, valid}, used for both IF/ID and the hold buffer.
- One sub-module, if_id_reg: IF/ID register with load, bubble and hold controls, also instantiated for the hold buffer. FSM and PC logic stay in if_stage.

## Test plan
- Reset release, imem_ready tied 1, RESET_PC=0: imem_addr 0,4,8 on cycles 2,3,4. inst=mem[0] at cycle 3 with pc_p4=4, id_valid=1.
- Instruction memory with 2 wait states: two bubbles (id_valid=0, inst=NOP_INST) precede each valid word; perf_wait+=2 per fetch.
- BRANCH=1, target=0x100, stall=0 while pc=0x10: next IF/ID is a bubble, next imem_addr=0x100, pc_p4 of the following valid instruction is 0x104, perf_squash=1.
- stall=1 for 3 cycles, arriving with imem_ready on word at 0x20: state HOLD, inst unchanged. On release inst=mem[0x20] with pc_p4=0x24; next fetch is at 0x24.
- stall=1 and BRANCH=1 together: no redirect, PC frozen. Stall drops with BRANCH=1, target=0x40: hold buffer dropped, bubble, fetch 0x40.
- pc=0xFFFF_FFFC fetched: pc_p4=0, next imem_addr=0. rst_n low during a waiting fetch: imem_req=0 next cycle and pc=RESET_PC.
